// File: rtl/riscv_pkg.sv
// Shared RISC-V core constants and types used by the register file slice.
package riscv_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned ZERO_REG = 0;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]   xlen_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard: issue reserves rd, writeback clears it, flush clears everything.
module regfile_scoreboard import riscv_pkg::*; #(
    parameter int unsigned NREGS = 32,
    parameter int unsigned AW    = $clog2(NREGS)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_rsv_en,
    input  logic [AW-1:0]    i_rsv_addr,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic             i_flush,
    output logic [NREGS-1:0] o_busy_vec
);

    // x0 has no flop; its busy bit is tied low at the output.
    logic [NREGS-1:1] r_busy;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_busy <= '0;
        end else if (i_flush) begin
            r_busy <= '0;
        end else begin
            for (int unsigned r = 1; r < NREGS; r++) begin
                if (i_rsv_en && (i_rsv_addr == AW'(r)))
                    r_busy[r] <= 1'b1;
                else if (i_wr_en && (i_wr_addr == AW'(r)))
                    r_busy[r] <= 1'b0;
            end
        end
    end

    assign o_busy_vec = {r_busy, 1'b0};

endmodule

// File: rtl/register_file_mp.sv
// Multi-read-port integer register file with integrated busy scoreboard.
// Optional REGFILE_BYPASS_EN forwards same-cycle write data to reads.
module register_file_mp import riscv_pkg::*; #(
    parameter int unsigned XLEN  = riscv_pkg::XLEN,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NREAD = 2,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [NREAD-1:0]      i_rd_en,
    input  logic [NREAD*AW-1:0]   i_rd_addr,
    output logic [NREAD*XLEN-1:0] o_rd_data,
    output logic [NREAD-1:0]      o_rd_busy,
    input  logic                  i_wr_en,
    input  logic [AW-1:0]         i_wr_addr,
    input  logic [XLEN-1:0]       i_wr_data,
    input  logic                  i_rsv_en,
    input  logic [AW-1:0]         i_rsv_addr,
    input  logic                  i_flush,
    output logic [NREGS-1:0]      o_busy_vec
);

    logic [XLEN-1:0]       r_regs [NREGS];
    logic [NREAD*XLEN-1:0] r_rd_data;
    logic [NREAD-1:0]      r_rd_busy;
    logic [NREAD*XLEN-1:0] w_rd_data_nxt;
    logic [NREAD-1:0]      w_rd_busy_nxt;
    logic [NREGS-1:0]      w_busy_vec;

    regfile_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_rsv_en   (i_rsv_en),
        .i_rsv_addr (i_rsv_addr),
        .i_wr_en    (i_wr_en),
        .i_wr_addr  (i_wr_addr),
        .i_flush    (i_flush),
        .o_busy_vec (w_busy_vec)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int unsigned r = 0; r < NREGS; r++)
                r_regs[r] <= '0;
        end else if (i_wr_en && (i_wr_addr != AW'(ZERO_REG))) begin
            r_regs[i_wr_addr] <= i_wr_data;
        end
    end

    for (genvar p = 0; p < NREAD; p++) begin : g_read
        logic [AW-1:0] w_addr;
        assign w_addr = i_rd_addr[p*AW +: AW];

        always_comb begin
            w_rd_data_nxt[p*XLEN +: XLEN] = r_regs[w_addr];
            w_rd_busy_nxt[p]              = w_busy_vec[w_addr];
`ifdef REGFILE_BYPASS_EN
            // Forwarded write retires the producer unless it is re-reserved this cycle.
            if (i_wr_en && (i_wr_addr == w_addr)) begin
                w_rd_data_nxt[p*XLEN +: XLEN] = i_wr_data;
                w_rd_busy_nxt[p]              = i_rsv_en && (i_rsv_addr == w_addr);
            end
`endif
            if (w_addr == AW'(ZERO_REG)) begin
                w_rd_data_nxt[p*XLEN +: XLEN] = '0;
                w_rd_busy_nxt[p]              = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rd_data <= '0;
            r_rd_busy <= '0;
        end else begin
            for (int unsigned p = 0; p < NREAD; p++) begin
                if (i_rd_en[p]) begin
                    r_rd_data[p*XLEN +: XLEN] <= w_rd_data_nxt[p*XLEN +: XLEN];
                    r_rd_busy[p]              <= w_rd_busy_nxt[p];
                end
            end
        end
    end

    assign o_rd_data  = r_rd_data;
    assign o_rd_busy  = r_rd_busy;
    assign o_busy_vec = w_busy_vec;

endmodule
